// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive controller: assembles NRZI-decoded bits into bytes,
// validates SYNC/PID, gates payload writes into the RX FIFO and flags packet status.
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_DATA  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_original,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic       d_edge,
  output logic [7:0] rcv_data,
  output logic       w_enable,
  output logic       rcving,
  output logic [3:0] rx_packet,
  output logic       rx_data_ready,
  output logic       r_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    PID   = 3'd2,
    TOKEN = 3'd3,
    DATA  = 3'd4,
    HSK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [6:0] BYTE_LIMIT = 7'(MAX_DATA + 2);

  // PID must be one of the supported types and carry its own complement in the upper nibble.
  function automatic logic pid_ok(input logic [7:0] b);
    logic known;
    case (b[3:0])
      4'b0001, 4'b1001, 4'b1101,
      4'b0011, 4'b1011,
      4'b0010, 4'b1010, 4'b1110: known = 1'b1;
      default:                   known = 1'b0;
    endcase
    pid_ok = known && (b[7:4] == ~b[3:0]);
  endfunction

  state_t     state_r, state_s;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] byte_cnt_r, byte_cnt_s;
  logic [7:0] rcv_data_r;
  logic       w_enable_r, w_enable_s;
  logic       rcving_r, rcving_s;
  logic [3:0] rx_packet_r, rx_packet_s;
  logic       rx_data_ready_r, rx_data_ready_s;
  logic       r_error_r, r_error_s;

  logic       active_s, shift_s, eop_s, byte_done_s, start_s;
  logic [7:0] byte_s;
  logic [6:0] byte_cnt_inc_s;

  // The EOP strobe never shifts; the edge cycle in IDLE never samples a bit.
  assign active_s       = (state_r == SYNC) || (state_r == PID) || (state_r == TOKEN) ||
                          (state_r == DATA) || (state_r == HSK);
  assign shift_s        = active_s && shift_enable && !eop;
  assign eop_s          = shift_enable && eop;
  assign byte_done_s    = shift_s && (bit_cnt_r == 3'd7);
  assign byte_s         = {d_original, shift_r[7:1]};
  assign start_s        = (state_r == IDLE) && d_edge;
  assign byte_cnt_inc_s = (byte_cnt_r == 7'h7F) ? byte_cnt_r : (byte_cnt_r + 7'd1);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s         = state_r;
    byte_cnt_s      = byte_cnt_r;
    w_enable_s      = 1'b0;
    rcving_s        = rcving_r;
    rx_packet_s     = rx_packet_r;
    rx_data_ready_s = 1'b0;
    r_error_s       = r_error_r;
    case (state_r)
      IDLE: begin
        if (d_edge) begin
          state_s     = SYNC;
          rcving_s    = 1'b1;
          r_error_s   = 1'b0;
          rx_packet_s = 4'h0;
          byte_cnt_s  = 7'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SYNC: begin
        if (eop_s) begin
          state_s   = IDLE;
          r_error_s = 1'b1;
          rcving_s  = 1'b0;
        end else if (byte_done_s) begin
          if (byte_s == SYNC_BYTE) begin
            state_s = PID;
          end else begin
            state_s   = ERR;
            r_error_s = 1'b1;
          end
        end else begin
          state_s = SYNC;
        end
      end
      PID: begin
        if (eop_s) begin
          state_s   = IDLE;
          r_error_s = 1'b1;
          rcving_s  = 1'b0;
        end else if (byte_done_s) begin
          if (pid_ok(byte_s)) begin
            rx_packet_s = byte_s[3:0];
            byte_cnt_s  = 7'd0;
            // PID[1:0] encodes the packet class: 01 token, 11 data, 10 handshake.
            case (byte_s[1:0])
              2'b01:   state_s = TOKEN;
              2'b11:   state_s = DATA;
              2'b10:   state_s = HSK;
              default: begin
                state_s   = ERR;
                r_error_s = 1'b1;
              end
            endcase
          end else begin
            state_s   = ERR;
            r_error_s = 1'b1;
          end
        end else begin
          state_s = PID;
        end
      end
      TOKEN: begin
        if (eop_s) begin
          if ((byte_cnt_r == 7'd2) && (bit_cnt_r == 3'd0)) begin
            state_s         = DONE;
            rx_data_ready_s = 1'b1;
            rcving_s        = 1'b0;
          end else begin
            state_s   = IDLE;
            r_error_s = 1'b1;
            rcving_s  = 1'b0;
          end
        end else if (byte_done_s) begin
          if (byte_cnt_r >= 7'd2) begin
            state_s   = ERR;
            r_error_s = 1'b1;
          end else begin
            byte_cnt_s = byte_cnt_inc_s;
          end
        end else begin
          state_s = TOKEN;
        end
      end
      DATA: begin
        if (eop_s) begin
          if ((bit_cnt_r == 3'd0) && (byte_cnt_r >= 7'd2)) begin
            state_s         = DONE;
            rx_data_ready_s = 1'b1;
            rcving_s        = 1'b0;
          end else begin
            state_s   = IDLE;
            r_error_s = 1'b1;
            rcving_s  = 1'b0;
          end
        end else if (byte_done_s) begin
          if (byte_cnt_r >= BYTE_LIMIT) begin
            state_s   = ERR;
            r_error_s = 1'b1;
          end else begin
            w_enable_s = 1'b1;
            byte_cnt_s = byte_cnt_inc_s;
          end
        end else begin
          state_s = DATA;
        end
      end
      HSK: begin
        if (eop_s) begin
          if (bit_cnt_r == 3'd0) begin
            state_s         = DONE;
            rx_data_ready_s = 1'b1;
            rcving_s        = 1'b0;
          end else begin
            state_s   = IDLE;
            r_error_s = 1'b1;
            rcving_s  = 1'b0;
          end
        end else if (byte_done_s) begin
          state_s   = ERR;
          r_error_s = 1'b1;
        end else begin
          state_s = HSK;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      ERR: begin
        if (eop_s) begin
          state_s  = IDLE;
          rcving_s = 1'b0;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s  = IDLE;
        rcving_s = 1'b0;
      end
    endcase
  end

  // Bit assembly: counters restart on every entry to SYNC.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (start_s) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (shift_s) begin
      shift_r   <= byte_s;
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered outputs; rcv_data and w_enable update on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rcv_data_r      <= 8'h00;
      byte_cnt_r      <= 7'd0;
      w_enable_r      <= 1'b0;
      rcving_r        <= 1'b0;
      rx_packet_r     <= 4'h0;
      rx_data_ready_r <= 1'b0;
      r_error_r       <= 1'b0;
    end else begin
      if (byte_done_s) begin
        rcv_data_r <= byte_s;
      end else begin
        rcv_data_r <= rcv_data_r;
      end
      byte_cnt_r      <= byte_cnt_s;
      w_enable_r      <= w_enable_s;
      rcving_r        <= rcving_s;
      rx_packet_r     <= rx_packet_s;
      rx_data_ready_r <= rx_data_ready_s;
      r_error_r       <= r_error_s;
    end
  end

  assign rcv_data      = rcv_data_r;
  assign w_enable      = w_enable_r;
  assign rcving        = rcving_r;
  assign rx_packet     = rx_packet_r;
  assign rx_data_ready = rx_data_ready_r;
  assign r_error       = r_error_r;

endmodule
